calc2_multi_port: RTL and testbench

Parametrised successor to the four-port calculator core. It has N independent request channels, each with a configurable data width and tag width, and per-channel request buffering so one channel can have several tagged requests outstanding. A single shared ALU is time-shared between channels by a round-robin arbiter. Each result is returned on its originating channel, tagged. The block sits between the calc request drivers and the response monitors, with the same two-cycle command/operand protocol.

---
 rtl/calc2_multi_port.sv | 257 +++++++++++++++++++++++++
 tb/tb_calc2_multi_port.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc2_multi_port.sv
// calc2_multi_port: N-channel tagged calculator with per-channel request FIFOs
// and one round-robin-shared ALU.
//   c_clk        : clock, all state on the rising edge
//   reset        : asynchronous active-high reset
//   req_cmd_in   : per-channel 4-bit command (0 = idle), channel k at [4k+3:4k]
//   req_tag_in   : per-channel tag, captured with a nonzero command
//   req_data_in  : per-channel operand A (cmd cycle) then operand B (next cycle)
//   req_rdy      : per-channel "command accepted this cycle" (combinational)
//   out_resp     : per-channel response code, valid for exactly one cycle
//   out_data     : per-channel result, zero unless out_resp = 01
//   out_tag      : per-channel tag of the returned request
module calc2_multi_port #(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 2
) (
    input  logic                     c_clk,
    input  logic                     reset,
    input  logic [N_CH*4-1:0]        req_cmd_in,
    input  logic [N_CH*TAG_W-1:0]    req_tag_in,
    input  logic [N_CH*DATA_W-1:0]   req_data_in,
    output logic [N_CH-1:0]          req_rdy,
    output logic [N_CH*2-1:0]        out_resp,
    output logic [N_CH*DATA_W-1:0]   out_data,
    output logic [N_CH*TAG_W-1:0]    out_tag
);

    localparam int unsigned DEPTH = 1 << TAG_W;
    localparam int unsigned CNT_W = TAG_W + 1;
    localparam int unsigned SH_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned PTR_W = $clog2(N_CH);

    localparam logic [1:0] RESP_OK  = 2'b01;
    localparam logic [1:0] RESP_OVF = 2'b10;
    localparam logic [1:0] RESP_INV = 2'b11;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_OPB  = 1'b1
    } cap_state_e;

    cap_state_e         r_state     [N_CH];
    cap_state_e         w_state_nxt [N_CH];

    logic [N_CH-1:0]    w_accept;
    logic [N_CH-1:0]    w_push;
    logic [N_CH-1:0]    w_pop;
    logic [N_CH-1:0]    w_full;
    logic [N_CH-1:0]    w_nempty;

    logic [3:0]         r_cap_cmd [N_CH];
    logic [TAG_W-1:0]   r_cap_tag [N_CH];
    logic [DATA_W-1:0]  r_cap_a   [N_CH];

    logic [3:0]         r_fifo_cmd [N_CH][DEPTH];
    logic [TAG_W-1:0]   r_fifo_tag [N_CH][DEPTH];
    logic [DATA_W-1:0]  r_fifo_a   [N_CH][DEPTH];
    logic [DATA_W-1:0]  r_fifo_b   [N_CH][DEPTH];
    logic [TAG_W-1:0]   r_wr_ptr   [N_CH];
    logic [TAG_W-1:0]   r_rd_ptr   [N_CH];
    logic [CNT_W-1:0]   r_count    [N_CH];

    logic [PTR_W-1:0]   r_rr_ptr;
    logic               w_gnt_vld;
    logic [PTR_W-1:0]   w_gnt;

    logic [3:0]         w_h_cmd;
    logic [TAG_W-1:0]   w_h_tag;
    logic [DATA_W-1:0]  w_h_a;
    logic [DATA_W-1:0]  w_h_b;
    logic [DATA_W:0]    w_sum;
    logic [1:0]         w_alu_resp;
    logic [DATA_W-1:0]  w_alu_data;

    // FIFO status flags
    always_comb begin
        w_full   = '0;
        w_nempty = '0;
        for (int k = 0; k < N_CH; k++) begin
            w_full[k]   = (r_count[k] == CNT_W'(DEPTH));
            w_nempty[k] = (r_count[k] != '0);
        end
    end

    // Capture FSM: state register
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N_CH; k++) r_state[k] <= S_IDLE;
        end else begin
            for (int k = 0; k < N_CH; k++) r_state[k] <= w_state_nxt[k];
        end
    end

    // Capture FSM: next state
    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            w_state_nxt[k] = r_state[k];
            case (r_state[k])
                S_IDLE:  if (w_accept[k]) w_state_nxt[k] = S_OPB;
                S_OPB:   w_state_nxt[k] = S_IDLE;
                default: w_state_nxt[k] = S_IDLE;
            endcase
        end
    end

    // Capture FSM: outputs. A cmd seen while not ready is simply dropped.
    always_comb begin
        req_rdy  = '0;
        w_accept = '0;
        w_push   = '0;
        for (int k = 0; k < N_CH; k++) begin
            req_rdy[k]  = !reset && (r_state[k] == S_IDLE) && !w_full[k];
            w_accept[k] = req_rdy[k] && (req_cmd_in[4*k +: 4] != 4'd0);
            w_push[k]   = (r_state[k] == S_OPB);
        end
    end

    // Command, tag and operand A held across the OPB cycle
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N_CH; k++) begin
                r_cap_cmd[k] <= '0;
                r_cap_tag[k] <= '0;
                r_cap_a[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (w_accept[k]) begin
                    r_cap_cmd[k] <= req_cmd_in[4*k +: 4];
                    r_cap_tag[k] <= req_tag_in[TAG_W*k +: TAG_W];
                    r_cap_a[k]   <= req_data_in[DATA_W*k +: DATA_W];
                end
            end
        end
    end

    // FIFO storage; contents are don't-care while the pointers say empty
    always_ff @(posedge c_clk) begin
        for (int k = 0; k < N_CH; k++) begin
            if (w_push[k]) begin
                r_fifo_cmd[k][r_wr_ptr[k]] <= r_cap_cmd[k];
                r_fifo_tag[k][r_wr_ptr[k]] <= r_cap_tag[k];
                r_fifo_a[k][r_wr_ptr[k]]   <= r_cap_a[k];
                r_fifo_b[k][r_wr_ptr[k]]   <= req_data_in[DATA_W*k +: DATA_W];
            end
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at 2**TAG_W
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N_CH; k++) begin
                r_wr_ptr[k] <= '0;
                r_rd_ptr[k] <= '0;
                r_count[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (w_push[k]) r_wr_ptr[k] <= r_wr_ptr[k] + TAG_W'(1);
                if (w_pop[k])  r_rd_ptr[k] <= r_rd_ptr[k] + TAG_W'(1);
                r_count[k] <= r_count[k] + CNT_W'(w_push[k]) - CNT_W'(w_pop[k]);
            end
        end
    end

    // Round-robin search starting at the pointer
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (!w_gnt_vld && w_nempty[(32'(r_rr_ptr) + 32'(i)) % N_CH]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = PTR_W'((32'(r_rr_ptr) + 32'(i)) % N_CH);
            end
        end
    end

    always_comb begin
        w_pop = '0;
        for (int k = 0; k < N_CH; k++) begin
            w_pop[k] = w_gnt_vld && (w_gnt == PTR_W'(k));
        end
    end

    // Pointer moves just past the granted channel, holds when idle
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr <= '0;
        end else if (w_gnt_vld) begin
            r_rr_ptr <= (w_gnt == PTR_W'(N_CH - 1)) ? '0 : w_gnt + PTR_W'(1);
        end
    end

    // Head entry of the granted FIFO
    always_comb begin
        w_h_cmd = r_fifo_cmd[w_gnt][r_rd_ptr[w_gnt]];
        w_h_tag = r_fifo_tag[w_gnt][r_rd_ptr[w_gnt]];
        w_h_a   = r_fifo_a[w_gnt][r_rd_ptr[w_gnt]];
        w_h_b   = r_fifo_b[w_gnt][r_rd_ptr[w_gnt]];
    end

    // Shared unsigned ALU
    always_comb begin
        w_sum      = {1'b0, w_h_a} + {1'b0, w_h_b};
        w_alu_resp = RESP_INV;
        w_alu_data = '0;
        case (w_h_cmd)
            4'd1: begin
                if (w_sum[DATA_W]) begin
                    w_alu_resp = RESP_OVF;
                end else begin
                    w_alu_resp = RESP_OK;
                    w_alu_data = w_sum[DATA_W-1:0];
                end
            end
            4'd2: begin
                if (w_h_b > w_h_a) begin
                    w_alu_resp = RESP_OVF;
                end else begin
                    w_alu_resp = RESP_OK;
                    w_alu_data = w_h_a - w_h_b;
                end
            end
            4'd5: begin
                w_alu_resp = RESP_OK;
                w_alu_data = w_h_a << w_h_b[SH_W-1:0];
            end
            4'd6: begin
                w_alu_resp = RESP_OK;
                w_alu_data = w_h_a >> w_h_b[SH_W-1:0];
            end
            default: ;
        endcase
    end

    // One-cycle response on the granted channel, zeros elsewhere
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            out_resp <= '0;
            out_data <= '0;
            out_tag  <= '0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (w_pop[k]) begin
                    out_resp[2*k +: 2]           <= w_alu_resp;
                    out_data[DATA_W*k +: DATA_W] <= w_alu_data;
                    out_tag[TAG_W*k +: TAG_W]    <= w_h_tag;
                end else begin
                    out_resp[2*k +: 2]           <= '0;
                    out_data[DATA_W*k +: DATA_W] <= '0;
                    out_tag[TAG_W*k +: TAG_W]    <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_calc2_multi_port.sv
// Testbench for calc2_multi_port (N_CH=4, DATA_W=32, TAG_W=2).
module tb_calc2_multi_port;

    localparam int unsigned N_CH   = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned TAG_W  = 2;

    logic                    clk;
    logic                    rst;
    logic [N_CH*4-1:0]       cmd_in;
    logic [N_CH*TAG_W-1:0]   tag_in;
    logic [N_CH*DATA_W-1:0]  data_in;
    logic [N_CH-1:0]         rdy;
    logic [N_CH*2-1:0]       resp;
    logic [N_CH*DATA_W-1:0]  dout;
    logic [N_CH*TAG_W-1:0]   tout;

    calc2_multi_port #(.N_CH(N_CH), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .c_clk       (clk),
        .reset       (rst),
        .req_cmd_in  (cmd_in),
        .req_tag_in  (tag_in),
        .req_data_in (data_in),
        .req_rdy     (rdy),
        .out_resp    (resp),
        .out_data    (dout),
        .out_tag     (tout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        int          ch;
        logic [3:0]  cmd;
        logic [1:0]  tag;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  resp;
        logic [31:0] data;
    } vec_t;

    int n_pass  = 0;
    int n_total = 0;

    vec_t vecs[11];

    // flood-phase bookkeeping
    int          acc[4];
    int          seen[4];
    int          pushed[4];
    int          seqn[4];
    bit          phase_b[4];
    bit          pend_push[4];
    bit          active[4];
    logic [31:0] pend_b[4];
    logic [31:0] exp_d[4][128];
    logic [1:0]  exp_t[4][128];
    int          streak;
    int          max_streak;
    int          ch2_drops;
    int          s;
    logic [31:0] fa;
    logic [31:0] fb;
    bit          done;
    logic [31:0] add_exp[4];
    logic [31:0] sub_exp[4];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic set_ch(input int ch, input logic [3:0] c, input logic [1:0] t, input logic [31:0] d);
        cmd_in[4*ch +: 4]   = c;
        tag_in[2*ch +: 2]   = t;
        data_in[32*ch +: 32] = d;
    endtask

    task automatic check_out(input string nm, input logic [7:0] er, input logic [127:0] ed, input logic [7:0] et);
        chk({nm, "_resp"}, 128'(resp), 128'(er));
        chk({nm, "_data"}, dout, ed);
        chk({nm, "_tag"}, 128'(tout), 128'(et));
    endtask

    task automatic check_one(input string nm, input int ch, input logic [1:0] r, input logic [31:0] d, input logic [1:0] t);
        logic [7:0]   er;
        logic [127:0] ed;
        logic [7:0]   et;
        er = '0; ed = '0; et = '0;
        er[2*ch +: 2]   = r;
        ed[32*ch +: 32] = d;
        et[2*ch +: 2]   = t;
        check_out(nm, er, ed, et);
    endtask

    // single uncontended request: cmd, operand B, response three cycles after cmd
    task automatic run_vec(input vec_t v, input string nm);
        set_ch(v.ch, v.cmd, v.tag, v.a);
        chk({nm, "_rdy_idle"}, 128'(rdy[v.ch]), 128'(1));
        step();
        set_ch(v.ch, 4'd0, 2'd0, v.b);
        chk({nm, "_rdy_opb"}, 128'(rdy[v.ch]), 128'(0));
        step();
        set_ch(v.ch, 4'd0, 2'd0, 32'd0);
        check_out({nm, "_early"}, 8'd0, 128'd0, 8'd0);
        step();
        check_one(nm, v.ch, v.resp, v.data, v.tag);
        step();
        check_out({nm, "_hold"}, 8'd0, 128'd0, 8'd0);
    endtask

    initial begin
        vecs[0]  = '{0, 4'd1,  2'd2, 32'd5,          32'd7,  2'b01, 32'd12};
        vecs[1]  = '{1, 4'd1,  2'd1, 32'hFFFF_FFFF,  32'd1,  2'b10, 32'd0};
        vecs[2]  = '{1, 4'd2,  2'd3, 32'd3,          32'd4,  2'b10, 32'd0};
        vecs[3]  = '{1, 4'd9,  2'd0, 32'd10,         32'd20, 2'b11, 32'd0};
        vecs[4]  = '{2, 4'd2,  2'd1, 32'd10,         32'd3,  2'b01, 32'd7};
        vecs[5]  = '{0, 4'd1,  2'd3, 32'hFFFF_FFFE,  32'd1,  2'b01, 32'hFFFF_FFFF};
        vecs[6]  = '{0, 4'd2,  2'd0, 32'd4,          32'd4,  2'b01, 32'd0};
        vecs[7]  = '{1, 4'd5,  2'd2, 32'h0000_00F0,  32'd32, 2'b01, 32'h0000_00F0};
        vecs[8]  = '{2, 4'd15, 2'd3, 32'd1,          32'd1,  2'b11, 32'd0};
        vecs[9]  = '{3, 4'd5,  2'd2, 32'd1,          32'd35, 2'b01, 32'd8};
        vecs[10] = '{3, 4'd6,  2'd1, 32'h8000_0000,  32'd31, 2'b01, 32'd1};

        add_exp[0] = 32'd3;  add_exp[1] = 32'd14; add_exp[2] = 32'd25; add_exp[3] = 32'd36;
        sub_exp[0] = 32'd50; sub_exp[1] = 32'd49; sub_exp[2] = 32'd48; sub_exp[3] = 32'd47;

        // reset state
        rst = 1'b1; cmd_in = '0; tag_in = '0; data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rdy", 128'(rdy), 128'(0));
        check_out("reset_out", 8'd0, 128'd0, 8'd0);
        rst = 1'b0;
        #1;
        chk("release_rdy", 128'(rdy), 128'(4'hF));
        step();

        // table-driven single requests; the last one is on ch3 so the pointer ends at 0
        for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // all four channels on the same edge, twice; second round proves pointer is back at 0
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) begin
                if (r == 0) set_ch(k, 4'd1, 2'(k), 32'(10*k + 1));
                else        set_ch(k, 4'd2, 2'(3 - k), 32'd50);
            end
            step();
            for (int k = 0; k < 4; k++) set_ch(k, 4'd0, 2'd0, (r == 0) ? 32'(k + 2) : 32'(k));
            chk($sformatf("all%0d_rdy_opb", r), 128'(rdy), 128'(0));
            step();
            for (int k = 0; k < 4; k++) set_ch(k, 4'd0, 2'd0, 32'd0);
            check_out($sformatf("all%0d_early", r), 8'd0, 128'd0, 8'd0);
            for (int j = 0; j < 4; j++) begin
                step();
                if (r == 0) check_one($sformatf("all%0d_ch%0d", r, j), j, 2'b01, add_exp[j], 2'(j));
                else        check_one($sformatf("all%0d_ch%0d", r, j), j, 2'b01, sub_exp[j], 2'(3 - j));
            end
            step();
            check_out($sformatf("all%0d_after", r), 8'd0, 128'd0, 8'd0);
        end

        // reset while ch0 is in OPB and ch3 holds two queued entries
        for (int k = 0; k < 4; k++) set_ch(k, 4'd1, 2'(k), 32'(k));
        step();
        for (int k = 0; k < 4; k++) set_ch(k, 4'd0, 2'd0, 32'd1);
        step();
        for (int k = 0; k < 3; k++) set_ch(k, 4'd0, 2'd0, 32'd0);
        set_ch(3, 4'd1, 2'd0, 32'd7);
        step();
        set_ch(3, 4'd0, 2'd0, 32'd1);
        set_ch(0, 4'd1, 2'd1, 32'd9);
        step();
        set_ch(0, 4'd0, 2'd0, 32'd5);
        set_ch(3, 4'd0, 2'd0, 32'd0);
        check_one("rst_pre_ch1", 1, 2'b01, 32'd2, 2'd1);
        chk("rst_pre_ch0_opb", 128'(rdy[0]), 128'(0));
        rst = 1'b1;
        #1;
        check_out("rst_mid_out", 8'd0, 128'd0, 8'd0);
        chk("rst_mid_rdy", 128'(rdy), 128'(0));
        cmd_in = '0; tag_in = '0; data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_rel_rdy", 128'(rdy), 128'(4'hF));
        for (int i = 0; i < 8; i++) begin
            step();
            check_out($sformatf("no_stale%0d", i), 8'd0, 128'd0, 8'd0);
        end
        run_vec('{3, 4'd1, 2'd2, 32'd100, 32'd23, 2'b01, 32'd123}, "post_rst");

        // flood: all channels stream adds; ch2 stops after its first dropped cmd
        for (int k = 0; k < 4; k++) begin
            acc[k] = 0; seen[k] = 0; pushed[k] = 0; seqn[k] = 0;
            phase_b[k] = 0; pend_push[k] = 0; active[k] = 1; pend_b[k] = '0;
        end
        streak = 0; max_streak = 0; ch2_drops = 0; done = 0;
        for (int cyc = 0; cyc < 600 && !done; cyc++) begin
            for (int k = 0; k < 4; k++) begin
                if (pend_push[k]) begin
                    pushed[k]++;
                    pend_push[k] = 0;
                end
            end
            for (int k = 0; k < 4; k++) begin
                if (resp[2*k +: 2] != 2'b00) begin
                    if (seen[k] < acc[k]) begin
                        chk($sformatf("flood_ch%0d_resp", k), 128'(resp[2*k +: 2]), 128'(2'b01));
                        chk($sformatf("flood_ch%0d_data", k), 128'(dout[32*k +: 32]), 128'(exp_d[k][seen[k]]));
                        chk($sformatf("flood_ch%0d_tag", k), 128'(tout[2*k +: 2]), 128'(exp_t[k][seen[k]]));
                    end else begin
                        chk($sformatf("flood_ch%0d_unexpected", k), 128'(resp[2*k +: 2]), 128'(0));
                    end
                    seen[k]++;
                    if (k == 2) streak = 0;
                end
            end
            if (pushed[2] - seen[2] > 0) begin
                streak++;
                if (streak > max_streak) max_streak = streak;
            end else begin
                streak = 0;
            end
            if (cyc == 60) for (int k = 0; k < 4; k++) active[k] = 0;
            for (int k = 0; k < 4; k++) begin
                if (phase_b[k]) begin
                    set_ch(k, 4'd0, 2'd0, pend_b[k]);
                    chk($sformatf("flood_ch%0d_rdy_opb", k), 128'(rdy[k]), 128'(0));
                    phase_b[k]   = 0;
                    pend_push[k] = 1;
                end else if (active[k]) begin
                    s  = seqn[k];
                    seqn[k]++;
                    fa = 32'(k) * 32'h1000 + 32'(s);
                    fb = 32'(s);
                    set_ch(k, 4'd1, 2'(s), fa);
                    if (k == 2) chk("flood_ch2_rdy", 128'(rdy[2]), 128'((pushed[2] - seen[2]) < 4));
                    if (rdy[k]) begin
                        exp_d[k][acc[k]] = fa + fb;
                        exp_t[k][acc[k]] = 2'(s);
                        acc[k]++;
                        phase_b[k] = 1;
                        pend_b[k]  = fb;
                    end else if (k == 2) begin
                        ch2_drops++;
                        active[2] = 0;
                    end
                end else begin
                    set_ch(k, 4'd0, 2'd0, 32'd0);
                end
            end
            if (cyc > 60) begin
                done = 1;
                for (int k = 0; k < 4; k++) begin
                    if (seen[k] != acc[k] || phase_b[k] || pend_push[k]) done = 0;
                end
            end
            step();
        end
        for (int k = 0; k < 4; k++) chk($sformatf("flood_ch%0d_drained", k), 128'(seen[k]), 128'(acc[k]));
        chk("flood_ch2_one_drop", 128'(ch2_drops), 128'(1));
        chk("flood_ch2_acc_ge4", 128'(acc[2] >= 4), 128'(1));
        chk("flood_ch2_service_gap", 128'(max_streak <= int'(N_CH)), 128'(1));
        step();
        check_out("flood_idle", 8'd0, 128'd0, 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
